// File: rtl/rob_pkg.sv
// Shared opcodes, op classes, entry layout and commit-FSM states for reorder_queue.
package rob_pkg;

    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_SUB  = 6'd1;
    localparam logic [5:0] OP_AND  = 6'd2;
    localparam logic [5:0] OP_OR   = 6'd3;
    localparam logic [5:0] OP_SLT  = 6'd4;
    localparam logic [5:0] OP_ADDI = 6'd5;
    localparam logic [5:0] OP_LW   = 6'd6;
    localparam logic [5:0] OP_SW   = 6'd7;
    localparam logic [5:0] OP_BNE  = 6'd8;
    localparam logic [5:0] OP_HALT = 6'd63;

    typedef enum logic [1:0] {
        CLS_ALU,
        CLS_STORE,
        CLS_BRANCH,
        CLS_HALT
    } op_class_e;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STORE_WAIT,
        ST_HALTED
    } commit_state_e;

    typedef struct packed {
        logic       valid;
        logic       ready;
        logic [5:0] op;
        logic [4:0] dest;
    } rob_entry_t;

    // Anything that is not a store, branch or halt writes the register file.
    function automatic op_class_e op_class(input logic [5:0] op);
        case (op)
            OP_SW:   return CLS_STORE;
            OP_BNE:  return CLS_BRANCH;
            OP_HALT: return CLS_HALT;
            default: return CLS_ALU;
        endcase
    endfunction

endpackage

// File: rtl/rob_read_port.sv
// One tag-indexed operand read port; forwards a same-cycle CDB hit when ROB_CDB_BYPASS_EN is defined.
module rob_read_port
    import rob_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int XLEN    = 32,
    parameter int NUM_CDB = 2,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic [IDX_W-1:0]             tag_i,
    input  logic [DEPTH-1:0][XLEN-1:0]   value_i,
    input  logic [DEPTH-1:0]             ready_i,
    input  logic [NUM_CDB-1:0]           cdb_valid_i,
    input  logic [NUM_CDB*IDX_W-1:0]     cdb_tag_i,
    input  logic [NUM_CDB*XLEN-1:0]      cdb_data_i,
    output logic [XLEN-1:0]              data_o,
    output logic                         ready_o
);

`ifdef ROB_CDB_BYPASS_EN
    // Later channels overwrite earlier ones, so the highest matching channel wins.
    always_comb begin
        data_o  = value_i[tag_i];
        ready_o = ready_i[tag_i];
        for (int c = 0; c < NUM_CDB; c++) begin
            if (cdb_valid_i[c] && (cdb_tag_i[c*IDX_W +: IDX_W] == tag_i)) begin
                data_o  = cdb_data_i[c*XLEN +: XLEN];
                ready_o = 1'b1;
            end
        end
    end
`else
    logic unused_cdb;

    always_comb begin
        data_o  = value_i[tag_i];
        ready_o = ready_i[tag_i];
    end

    assign unused_cdb = ^{cdb_valid_i, cdb_tag_i, cdb_data_i};
`endif

endmodule

// File: rtl/reorder_queue.sv
// Parametrised in-order commit buffer with registered commit outputs, store wait and mispredict flush.
// Optional same-cycle CDB forwarding on read ports: define ROB_CDB_BYPASS_EN.
module reorder_queue
    import rob_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int XLEN    = 32,
    parameter int NUM_CDB = 2,
    parameter int NUM_RD  = 4,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issueValid,
    output logic                      issueReady,
    input  logic [5:0]                issueOp,
    input  logic [4:0]                issueDest,
    input  logic [XLEN-1:0]           issuePc,
    input  logic [XLEN-1:0]           issueTarget,
    output logic [IDX_W-1:0]          issueTag,
    input  logic [NUM_CDB-1:0]        cdbValid,
    input  logic [NUM_CDB*IDX_W-1:0]  cdbTag,
    input  logic [NUM_CDB*XLEN-1:0]   cdbData,
    input  logic [NUM_CDB*XLEN-1:0]   cdbAddr,
    input  logic [NUM_RD*IDX_W-1:0]   rdTag,
    output logic [NUM_RD*XLEN-1:0]    rdData,
    output logic [NUM_RD-1:0]         rdReady,
    output logic                      regWe,
    output logic [4:0]                regWaddr,
    output logic [XLEN-1:0]           regWdata,
    output logic [IDX_W-1:0]          regWtag,
    output logic                      memWe,
    output logic [XLEN-1:0]           memAddr,
    output logic [XLEN-1:0]           memData,
    input  logic                      memDone,
    output logic [XLEN-1:0]           brPc,
    input  logic [1:0]                brPred,
    output logic                      brValid,
    output logic                      brTaken,
    output logic                      brMispredict,
    output logic [XLEN-1:0]           redirectPc,
    output logic                      flush,
    output logic                      halt,
    output logic [IDX_W:0]            count
);

    localparam int CNT_W = IDX_W + 1;

    rob_entry_t [DEPTH-1:0]           ent_q, ent_d;
    logic [DEPTH-1:0][XLEN-1:0]       pc_q, pc_d;
    logic [DEPTH-1:0][XLEN-1:0]       tgt_q, tgt_d;
    logic [DEPTH-1:0][XLEN-1:0]       val_q, val_d;
    logic [DEPTH-1:0][XLEN-1:0]       addr_q, addr_d;
    logic [IDX_W-1:0]                 head_q, head_d;
    logic [IDX_W-1:0]                 tail_q, tail_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    commit_state_e                    state_q, state_d;

    logic                             reg_we_q, reg_we_d;
    logic [4:0]                       reg_waddr_q, reg_waddr_d;
    logic [XLEN-1:0]                  reg_wdata_q, reg_wdata_d;
    logic [IDX_W-1:0]                 reg_wtag_q, reg_wtag_d;
    logic                             mem_we_q, mem_we_d;
    logic [XLEN-1:0]                  mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]                  mem_data_q, mem_data_d;
    logic                             br_valid_q, br_valid_d;
    logic                             br_taken_q, br_taken_d;
    logic                             br_mis_q, br_mis_d;
    logic [XLEN-1:0]                  redirect_q, redirect_d;
    logic                             flush_q, flush_d;
    logic                             halt_q, halt_d;

    rob_entry_t                       head_e;
    logic                             issue_fire;
    logic                             retire;
    logic                             mispredict;
    logic                             taken;
    logic [IDX_W-1:0]                 ctag;
    logic [DEPTH-1:0]                 rd_ready_vec;
    logic                             unused_brpred;

    assign head_e        = ent_q[head_q];
    assign issueReady    = (cnt_q < CNT_W'(DEPTH)) && !halt_q;
    assign issue_fire    = issueValid && issueReady;
    assign issueTag      = tail_q;
    assign brPc          = pc_q[head_q];
    assign count         = cnt_q;
    assign unused_brpred = brPred[0];

    always_comb begin
        ent_d       = ent_q;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        val_d       = val_q;
        addr_d      = addr_q;
        head_d      = head_q;
        tail_d      = tail_q;
        cnt_d       = cnt_q;
        state_d     = state_q;
        reg_we_d    = 1'b0;
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;
        reg_wtag_d  = reg_wtag_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        br_valid_d  = 1'b0;
        br_taken_d  = 1'b0;
        br_mis_d    = 1'b0;
        redirect_d  = redirect_q;
        flush_d     = 1'b0;
        halt_d      = halt_q;
        retire      = 1'b0;
        mispredict  = 1'b0;
        taken       = 1'b0;
        ctag        = '0;

        case (state_q)
            ST_RUN: begin
                if (head_e.valid && head_e.ready) begin
                    case (op_class(head_e.op))
                        CLS_ALU: begin
                            reg_we_d    = 1'b1;
                            reg_waddr_d = head_e.dest;
                            reg_wdata_d = val_q[head_q];
                            reg_wtag_d  = head_q;
                            retire      = 1'b1;
                        end
                        CLS_STORE: begin
                            mem_we_d   = 1'b1;
                            mem_addr_d = addr_q[head_q];
                            mem_data_d = val_q[head_q];
                            state_d    = ST_STORE_WAIT;
                        end
                        CLS_BRANCH: begin
                            taken      = (val_q[head_q] != '0);
                            br_valid_d = 1'b1;
                            br_taken_d = taken;
                            retire     = 1'b1;
                            if (taken != brPred[1]) begin
                                mispredict = 1'b1;
                                br_mis_d   = 1'b1;
                                flush_d    = 1'b1;
                                redirect_d = taken ? tgt_q[head_q] : pc_q[head_q] + XLEN'(1);
                            end
                        end
                        default: begin
                            halt_d  = 1'b1;
                            state_d = ST_HALTED;
                            retire  = 1'b1;
                        end
                    endcase
                end
            end
            ST_STORE_WAIT: begin
                if (memDone) begin
                    mem_we_d = 1'b0;
                    retire   = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            default: ;
        endcase

        // Eligibility is judged on registered state so a higher channel can overwrite a lower one.
        for (int c = 0; c < NUM_CDB; c++) begin
            if (cdbValid[c]) begin
                ctag = cdbTag[c*IDX_W +: IDX_W];
                if (ent_q[ctag].valid && !ent_q[ctag].ready) begin
                    ent_d[ctag].ready = 1'b1;
                    val_d[ctag]       = cdbData[c*XLEN +: XLEN];
                    addr_d[ctag]      = cdbAddr[c*XLEN +: XLEN];
                end
            end
        end

        if (retire) begin
            ent_d[head_q].valid = 1'b0;
            ent_d[head_q].ready = 1'b0;
        end

        if (issue_fire) begin
            ent_d[tail_q].valid = 1'b1;
            ent_d[tail_q].ready = (issueOp == OP_HALT);
            ent_d[tail_q].op    = issueOp;
            ent_d[tail_q].dest  = issueDest;
            pc_d[tail_q]        = issuePc;
            tgt_d[tail_q]       = issueTarget;
            tail_d              = tail_q + IDX_W'(1);
        end

        cnt_d  = cnt_q + CNT_W'(issue_fire) - CNT_W'(retire);
        head_d = head_q + IDX_W'(retire);

        // A mispredict squashes everything younger, including a same-cycle issue.
        if (mispredict) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].valid = 1'b0;
            end
            head_d = head_q + IDX_W'(1);
            tail_d = head_q + IDX_W'(1);
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_q       <= '0;
            pc_q        <= '0;
            tgt_q       <= '0;
            val_q       <= '0;
            addr_q      <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= '0;
            state_q     <= ST_RUN;
            reg_we_q    <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
            reg_wtag_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            br_valid_q  <= 1'b0;
            br_taken_q  <= 1'b0;
            br_mis_q    <= 1'b0;
            redirect_q  <= '0;
            flush_q     <= 1'b0;
            halt_q      <= 1'b0;
        end else begin
            ent_q       <= ent_d;
            pc_q        <= pc_d;
            tgt_q       <= tgt_d;
            val_q       <= val_d;
            addr_q      <= addr_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            reg_we_q    <= reg_we_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_wtag_q  <= reg_wtag_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            br_valid_q  <= br_valid_d;
            br_taken_q  <= br_taken_d;
            br_mis_q    <= br_mis_d;
            redirect_q  <= redirect_d;
            flush_q     <= flush_d;
            halt_q      <= halt_d;
        end
    end

    assign regWe        = reg_we_q;
    assign regWaddr     = reg_waddr_q;
    assign regWdata     = reg_wdata_q;
    assign regWtag      = reg_wtag_q;
    assign memWe        = mem_we_q;
    assign memAddr      = mem_addr_q;
    assign memData      = mem_data_q;
    assign brValid      = br_valid_q;
    assign brTaken      = br_taken_q;
    assign brMispredict = br_mis_q;
    assign redirectPc   = redirect_q;
    assign flush        = flush_q;
    assign halt         = halt_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rd_ready_vec[i] = ent_q[i].valid && ent_q[i].ready;
        end
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        rob_read_port #(
            .DEPTH   (DEPTH),
            .XLEN    (XLEN),
            .NUM_CDB (NUM_CDB)
        ) u_rd (
            .tag_i       (rdTag[r*IDX_W +: IDX_W]),
            .value_i     (val_q),
            .ready_i     (rd_ready_vec),
            .cdb_valid_i (cdbValid),
            .cdb_tag_i   (cdbTag),
            .cdb_data_i  (cdbData),
            .data_o      (rdData[r*XLEN +: XLEN]),
            .ready_o     (rdReady[r])
        );
    end

endmodule

// File: tb/tb_reorder_queue.sv
// Directed bench for reorder_queue at DEPTH=4: commit classes, wrap, store wait, flush, halt and reset.
module tb_reorder_queue;
    import rob_pkg::*;

    logic         clk;
    logic         rst;
    logic         issueValid;
    logic         issueReady;
    logic [5:0]   issueOp;
    logic [4:0]   issueDest;
    logic [31:0]  issuePc;
    logic [31:0]  issueTarget;
    logic [1:0]   issueTag;
    logic [1:0]   cdbValid;
    logic [3:0]   cdbTag;
    logic [63:0]  cdbData;
    logic [63:0]  cdbAddr;
    logic [7:0]   rdTag;
    logic [127:0] rdData;
    logic [3:0]   rdReady;
    logic         regWe;
    logic [4:0]   regWaddr;
    logic [31:0]  regWdata;
    logic [1:0]   regWtag;
    logic         memWe;
    logic [31:0]  memAddr;
    logic [31:0]  memData;
    logic         memDone;
    logic [31:0]  brPc;
    logic [1:0]   brPred;
    logic         brValid;
    logic         brTaken;
    logic         brMispredict;
    logic [31:0]  redirectPc;
    logic         flush;
    logic         halt;
    logic [2:0]   count;

    int checks = 0;
    int errors = 0;

    reorder_queue #(.DEPTH(4), .XLEN(32), .NUM_CDB(2), .NUM_RD(4)) dut (
        .clk(clk), .rst(rst),
        .issueValid(issueValid), .issueReady(issueReady), .issueOp(issueOp),
        .issueDest(issueDest), .issuePc(issuePc), .issueTarget(issueTarget),
        .issueTag(issueTag),
        .cdbValid(cdbValid), .cdbTag(cdbTag), .cdbData(cdbData), .cdbAddr(cdbAddr),
        .rdTag(rdTag), .rdData(rdData), .rdReady(rdReady),
        .regWe(regWe), .regWaddr(regWaddr), .regWdata(regWdata), .regWtag(regWtag),
        .memWe(memWe), .memAddr(memAddr), .memData(memData), .memDone(memDone),
        .brPc(brPc), .brPred(brPred), .brValid(brValid), .brTaken(brTaken),
        .brMispredict(brMispredict), .redirectPc(redirectPc), .flush(flush),
        .halt(halt), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_issue(input logic [5:0] op, input logic [4:0] d,
                            input logic [31:0] pc, input logic [31:0] tgt);
        issueValid  = 1'b1;
        issueOp     = op;
        issueDest   = d;
        issuePc     = pc;
        issueTarget = tgt;
        step();
        issueValid  = 1'b0;
    endtask

    task automatic do_cdb(input logic [1:0] v, input logic [3:0] tags,
                          input logic [63:0] data, input logic [63:0] addr);
        cdbValid = v;
        cdbTag   = tags;
        cdbData  = data;
        cdbAddr  = addr;
        step();
        cdbValid = '0;
    endtask

    initial begin
        rst = 1'b0; issueValid = 1'b0; issueOp = '0; issueDest = '0; issuePc = '0;
        issueTarget = '0; cdbValid = '0; cdbTag = '0; cdbData = '0; cdbAddr = '0;
        rdTag = '0; memDone = 1'b0; brPred = '0;
        #2 rst = 1'b1;
        #1;
        chk("rst_issueReady", issueReady, 1);
        chk("rst_count", count, 0);
        chk("rst_regWe", regWe, 0);
        chk("rst_memWe", memWe, 0);
        chk("rst_halt", halt, 0);
        chk("rst_flush", flush, 0);
        chk("rst_brPc", brPc, 0);
        chk("rst_rdReady", rdReady, 0);
        step();
        rst = 1'b0;

        // ADD r3 into tag 0, then CDB writes 0x2A
        do_issue(OP_ADD, 5'd3, 32'h0, 32'h0);
        chk("add_count", count, 1);
        chk("add_issueTag", issueTag, 1);
        chk("add_rdReady_pre", rdReady[0], 0);
        do_cdb(2'b01, 4'b0000, 64'h2A, 64'h0);
        chk("add_rdReady", rdReady[0], 1);
        chk("add_rdData", rdData[31:0], 32'h2A);
        chk("add_regWe_early", regWe, 0);
        step();
        chk("add_regWe", regWe, 1);
        chk("add_regWaddr", regWaddr, 3);
        chk("add_regWdata", regWdata, 32'h2A);
        chk("add_regWtag", regWtag, 0);
        chk("add_count_after", count, 0);
        step();
        chk("add_regWe_pulse", regWe, 0);

        // fill to DEPTH with tail wrapping, then free one slot
        do_issue(OP_ADD, 5'd1, 32'h1, 32'h0);
        do_issue(OP_ADD, 5'd2, 32'h2, 32'h0);
        do_issue(OP_ADD, 5'd3, 32'h3, 32'h0);
        chk("fill_tail_wrap", issueTag, 0);
        do_issue(OP_ADD, 5'd4, 32'h4, 32'h0);
        chk("full_count", count, 4);
        chk("full_issueReady", issueReady, 0);
        chk("full_issueTag", issueTag, 1);
        do_issue(OP_ADD, 5'd9, 32'h9, 32'h0);
        chk("full_reject", count, 4);
        do_cdb(2'b01, 4'b0001, 64'h11, 64'h0);
        step();
        chk("free_regWtag", regWtag, 1);
        chk("free_regWdata", regWdata, 32'h11);
        chk("free_count", count, 3);
        chk("free_issueReady", issueReady, 1);
        do_issue(OP_ADD, 5'd5, 32'h5, 32'h0);
        chk("refill_count", count, 4);
        chk("refill_issueTag", issueTag, 2);

        // both channels hit tag 2: channel 1 wins
        rdTag    = {2'd0, 2'd0, 2'd2, 2'd0};
        cdbValid = 2'b11;
        cdbTag   = {2'd2, 2'd2};
        cdbData  = {32'd9, 32'd5};
        cdbAddr  = '0;
        #1;
`ifdef ROB_CDB_BYPASS_EN
        chk("byp_rdReady", rdReady[1], 1);
        chk("byp_rdData", rdData[63:32], 32'd9);
`else
        chk("nobyp_rdReady", rdReady[1], 0);
`endif
        step();
        cdbValid = '0;
        chk("dual_rdData", rdData[63:32], 32'd9);
        chk("dual_rdReady", rdReady[1], 1);
        step();
        chk("dual_regWe", regWe, 1);
        chk("dual_regWaddr", regWaddr, 2);
        chk("dual_regWdata", regWdata, 32'd9);
        do_cdb(2'b11, {2'd0, 2'd3}, {32'h44, 32'h33}, 64'h0);
        chk("drain_idle", regWe, 0);
        step();
        chk("drain_t3", regWdata, 32'h33);
        step();
        chk("drain_t0_we", regWe, 1);
        chk("drain_t0", regWdata, 32'h44);
        chk("drain_count", count, 1);
        do_cdb(2'b01, 4'b0001, 64'h55, 64'h0);
        step();
        chk("drain_t1", regWdata, 32'h55);
        chk("drain_empty", count, 0);

        // SW at head (tag 2) waits on memDone, ADD behind it (tag 3)
        do_issue(OP_SW, 5'd0, 32'h20, 32'h0);
        chk("sw_brPc", brPc, 32'h20);
        do_issue(OP_ADD, 5'd6, 32'h21, 32'h0);
        do_cdb(2'b11, {2'd3, 2'd2}, {32'h66, 32'd7}, {32'h0, 32'h100});
        step();
        chk("sw_memWe", memWe, 1);
        chk("sw_memAddr", memAddr, 32'h100);
        chk("sw_memData", memData, 32'd7);
        step();
        chk("sw_hold1", memWe, 1);
        step();
        chk("sw_hold2", memWe, 1);
        chk("sw_block_regWe", regWe, 0);
        chk("sw_block_count", count, 2);
        memDone = 1'b1;
        step();
        memDone = 1'b0;
        chk("sw_done_memWe", memWe, 0);
        chk("sw_done_count", count, 1);
        chk("sw_done_regWe", regWe, 0);
        step();
        chk("sw_next_regWe", regWe, 1);
        chk("sw_next_regWaddr", regWaddr, 6);
        chk("sw_next_regWdata", regWdata, 32'h66);

        // BNE taken, predicted not-taken: flush and discard same-cycle issue
        brPred = 2'b00;
        rdTag  = {2'd0, 2'd0, 2'd0, 2'd1};
        do_issue(OP_BNE, 5'd0, 32'h10, 32'h40);
        do_cdb(2'b01, 4'b0000, 64'h1, 64'h0);
        issueValid = 1'b1; issueOp = OP_ADD; issueDest = 5'd9;
        step();
        issueValid = 1'b0;
        chk("bne_brValid", brValid, 1);
        chk("bne_brTaken", brTaken, 1);
        chk("bne_mispredict", brMispredict, 1);
        chk("bne_redirect", redirectPc, 32'h40);
        chk("bne_flush", flush, 1);
        chk("bne_count", count, 0);
        chk("bne_tail", issueTag, 1);
        chk("bne_discard", rdReady[0], 0);
        step();
        chk("bne_flush_pulse", flush, 0);
        chk("bne_count_hold", count, 0);

        // BNE taken, predicted taken
        brPred = 2'b11;
        do_issue(OP_BNE, 5'd0, 32'h50, 32'h80);
        do_cdb(2'b01, 4'b0001, 64'h1, 64'h0);
        step();
        chk("bok_brValid", brValid, 1);
        chk("bok_mispredict", brMispredict, 0);
        chk("bok_flush", flush, 0);
        chk("bok_tail", issueTag, 2);

        // BNE not taken, predicted taken: redirect to pc+1
        brPred = 2'b10;
        do_issue(OP_BNE, 5'd0, 32'h60, 32'h90);
        do_cdb(2'b01, 4'b0010, 64'h0, 64'h0);
        step();
        brPred = 2'b00;
        chk("bnt_mispredict", brMispredict, 1);
        chk("bnt_brTaken", brTaken, 0);
        chk("bnt_redirect", redirectPc, 32'h61);
        chk("bnt_tail", issueTag, 3);

        // HALT behind two unready ADDs
        do_issue(OP_ADD, 5'd7, 32'h70, 32'h0);
        do_issue(OP_ADD, 5'd8, 32'h71, 32'h0);
        do_issue(OP_HALT, 5'd0, 32'h72, 32'h0);
        chk("halt_count", count, 3);
        step();
        chk("halt_wait0", halt, 0);
        do_cdb(2'b01, 4'b0011, 64'h70, 64'h0);
        step();
        chk("halt_t3_regWaddr", regWaddr, 7);
        chk("halt_wait1", halt, 0);
        do_cdb(2'b01, 4'b0000, 64'h80, 64'h0);
        step();
        chk("halt_t0_regWaddr", regWaddr, 8);
        chk("halt_wait2", halt, 0);
        step();
        chk("halt_set", halt, 1);
        chk("halt_count0", count, 0);
        chk("halt_issueReady", issueReady, 0);
        do_issue(OP_ADD, 5'd1, 32'h0, 32'h0);
        chk("halt_no_issue", count, 0);
        chk("halt_sticky", halt, 1);

        #2 rst = 1'b1;
        #1;
        chk("arst_halt", halt, 0);
        chk("arst_count", count, 0);
        chk("arst_issueReady", issueReady, 1);
        step();
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
